// File: rtl/retospect_cfg_pkg.sv
// Shared definitions for the neurochip configuration-chain loader.
//   state_e       : loader FSM states
//   CLOCKBOX_BITS : chain bits contributed by the clockbox
//   CNB_BITS      : chain bits contributed by each cnb
//   chain_len()   : total chain length for a given number of cnbs
package retospect_cfg_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    SHIFT,
    ARM,
    DONE
  } state_e;

  localparam int CLOCKBOX_BITS = 48;
  localparam int CNB_BITS      = 18;

  function automatic int chain_len(input int n_cnb);
    return CLOCKBOX_BITS + CNB_BITS * n_cnb;
  endfunction

endpackage

// File: rtl/retospect_bs_packer.sv
// Serial-to-parallel packer for bits returning from the chain tail.
//   clk, rst_n : clock, async active-low reset
//   clr        : drop any partial word and suppress output
//   sample_en  : capture bit_in this cycle
//   bit_in     : returned chain bit
//   flush      : the bit captured this cycle is the last of the load
//   rb_data    : packed word, LSB = first bit returned, unused MSBs zero
//   rb_valid   : one-cycle strobe for rb_data
module retospect_bs_packer #(
  parameter int WORD_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              sample_en,
  input  logic              bit_in,
  input  logic              flush,
  output logic [WORD_W-1:0] rb_data,
  output logic              rb_valid
);
  localparam int IW = $clog2(WORD_W);

  logic [WORD_W-1:0] acc_q, acc_d, word, rb_data_q, rb_data_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic              rb_valid_q, rb_valid_d;

  always_comb begin
    // accumulator is zero above idx, so a flushed partial word is zero-padded
    word        = acc_q;
    word[idx_q] = bit_in;
    acc_d       = acc_q;
    idx_d       = idx_q;
    rb_data_d   = rb_data_q;
    rb_valid_d  = 1'b0;
    if (clr) begin
      acc_d = '0;
      idx_d = '0;
    end else if (sample_en) begin
      if (flush || idx_q == IW'(WORD_W - 1)) begin
        rb_data_d  = word;
        rb_valid_d = 1'b1;
        acc_d      = '0;
        idx_d      = '0;
      end else begin
        acc_d = word;
        idx_d = idx_q + IW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q      <= '0;
      idx_q      <= '0;
      rb_data_q  <= '0;
      rb_valid_q <= 1'b0;
    end else begin
      acc_q      <= acc_d;
      idx_q      <= idx_d;
      rb_data_q  <= rb_data_d;
      rb_valid_q <= rb_valid_d;
    end
  end

  assign rb_data  = rb_data_q;
  assign rb_valid = rb_valid_q;

endmodule

// File: rtl/retospect_bs_loader.sv
// Host-side configuration-chain transmitter. Serializes WORD_W-bit words
// LSB-first onto the chain (bs_out qualified by config_en), packs the bits
// falling off the chain tail into readback words, and optionally pulses
// reset_nn once the full chain has been written.
//   start/abort          : begin a load (IDLE only) / abandon a load
//   in_data/in_valid/in_ready : word input handshake
//   config_en/bs_out     : registered shift enable and serial data
//   bs_return            : chain tail, sampled on each enabled shift edge
//   reset_nn             : registered one-cycle neuron re-arm pulse
//   rb_data/rb_valid     : readback words
//   busy/done            : not-IDLE flag / one-cycle completion pulse
module retospect_bs_loader
  import retospect_cfg_pkg::*;
#(
  parameter int CHAIN_LEN = chain_len(1),
  parameter int WORD_W    = 8,
  parameter bit ARM_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              config_en,
  output logic              bs_out,
  input  logic              bs_return,
  output logic              reset_nn,
  output logic [WORD_W-1:0] rb_data,
  output logic              rb_valid,
  output logic              busy,
  output logic              done
);
  localparam int CW = $clog2(CHAIN_LEN + 1);
  localparam int IW = $clog2(WORD_W);

  state_e            state_q, state_d;
  logic [CW-1:0]     bit_cnt_q, bit_cnt_d;
  logic [IW-1:0]     widx_q, widx_d;
  logic [WORD_W-1:0] shreg_q, shreg_d;
  logic              config_en_q, config_en_d, bs_out_q, bs_out_d;
  logic              reset_nn_q, reset_nn_d, done_q, done_d;
  logic              last_q, last_d;
  logic              kill, bit_last, word_last, rb_clr;

  assign kill      = abort && (state_q != IDLE);
  assign bit_last  = (bit_cnt_q == CW'(CHAIN_LEN - 1));
  assign word_last = (widx_q == IW'(WORD_W - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (kill) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (start) state_d = FETCH;
        FETCH:   if (in_valid) state_d = SHIFT;
        // chain end wins over word end: the tail of the last word is dropped
        SHIFT:   if (bit_last)       state_d = ARM_RESET ? ARM : DONE;
                 else if (word_last) state_d = FETCH;
        ARM:     state_d = DONE;
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Outputs are registered: what is decided in a state appears one cycle later.
  always_comb begin
    in_ready    = (state_q == FETCH) && !abort;
    busy        = (state_q != IDLE);
    shreg_d     = shreg_q;
    bit_cnt_d   = bit_cnt_q;
    widx_d      = widx_q;
    config_en_d = 1'b0;
    bs_out_d    = 1'b0;
    reset_nn_d  = 1'b0;
    done_d      = 1'b0;
    last_d      = 1'b0;
    if (!kill) begin
      case (state_q)
        IDLE: begin
          bit_cnt_d = '0;
          widx_d    = '0;
        end
        FETCH: if (in_valid) shreg_d = in_data;
        SHIFT: begin
          config_en_d = 1'b1;
          bs_out_d    = shreg_q[0];
          shreg_d     = shreg_q >> 1;
          bit_cnt_d   = bit_cnt_q + CW'(1);
          widx_d      = word_last ? '0 : widx_q + IW'(1);
          last_d      = bit_last;
        end
        ARM:     reset_nn_d = 1'b1;
        DONE:    done_d     = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg_q     <= '0;
      bit_cnt_q   <= '0;
      widx_q      <= '0;
      config_en_q <= 1'b0;
      bs_out_q    <= 1'b0;
      reset_nn_q  <= 1'b0;
      done_q      <= 1'b0;
      last_q      <= 1'b0;
    end else begin
      shreg_q     <= shreg_d;
      bit_cnt_q   <= bit_cnt_d;
      widx_q      <= widx_d;
      config_en_q <= config_en_d;
      bs_out_q    <= bs_out_d;
      reset_nn_q  <= reset_nn_d;
      done_q      <= done_d;
      last_q      <= last_d;
    end
  end

  assign config_en = config_en_q;
  assign bs_out    = bs_out_q;
  assign reset_nn  = reset_nn_q;
  assign done      = done_q;

  // The chain shifts on the edge that ends a config_en_q cycle, which is the
  // same edge that captures the old tail bit here.
  assign rb_clr = (state_q == IDLE) || abort;

  retospect_bs_packer #(.WORD_W(WORD_W)) u_packer (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (rb_clr),
    .sample_en (config_en_q),
    .bit_in    (bs_return),
    .flush     (last_q),
    .rb_data   (rb_data),
    .rb_valid  (rb_valid)
  );

endmodule
